controle_carga: RTL and testbench
=================================

CONTROLE_CARGA -- requirements
Module: controle_carga

Interface
REQ-001 SHALL have parameter LOAD, default 5'd1, the command code driven on tx to request the next memory value.
REQ-002 SHALL have parameter NOP, default 5'd0, the command code driven on tx when no request is made.
REQ-003 SHALL have parameter RODADAS, default 3, the number of load/execute rounds per start; legal range 1..31.
REQ-004 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  request a run; sampled only in OCIOSO.
REQ-007 SHALL have port entrada  input  5  value returned by the memory block.
REQ-008 SHALL have port tx  output  5  registered command to the memory block.
REQ-009 SHALL have port valor  output  5  last captured entrada.
REQ-010 SHALL have port etapa  output  5  remaining execute steps of the current round.
REQ-011 SHALL have port rodada  output  5  index of the current round, 0-based.
REQ-012 SHALL have port ocupado  output  1  high in every state except OCIOSO.
REQ-013 SHALL have port fim  output  1  one-cycle pulse when a run completes.
REQ-014 SHALL have port soma  output  8  accumulated total of captured values (see Configuration).

Function
REQ-015 SHALL implement the states OCIOSO, CARREGA, ESPERA, EXECUTA and FIM.
REQ-016 OCIOSO: when start=1, SHALL go to CARREGA and clear rodada and soma; otherwise SHALL stay in OCIOSO.
REQ-017 CARREGA: SHALL drive tx=LOAD for exactly this one cycle, then go to ESPERA.
REQ-018 In every state other than CARREGA, tx SHALL equal NOP, so the memory advances exactly once per round.
REQ-019 ESPERA: entrada is valid after the memory's update edge; at the end of ESPERA the block SHALL load valor<=entrada and etapa<=entrada.
REQ-020 Leaving ESPERA: if entrada≠0, SHALL go to EXECUTA; if entrada=0, SHALL skip EXECUTA and apply the round-end rule (REQ-022).
REQ-021 EXECUTA: SHALL decrement etapa by 1 each cycle and stay for exactly valor cycles, i.e. leave on the edge where etapa=1, with etapa becoming 0.
REQ-022 Round end: if rodada=RODADAS-1, SHALL go to FIM; otherwise SHALL increment rodada and go to CARREGA.
REQ-023 FIM: SHALL assert fim for one cycle, then return to OCIOSO; valor, soma and rodada SHALL hold until the next start.
REQ-024 start asserted while ocupado=1 SHALL be ignored and SHALL NOT queue a run.
REQ-025 Run length SHALL be 2×RODADAS + Σvalor cycles from the first CARREGA to FIM, plus 1 cycle in FIM.
REQ-026 Unreachable state encodings SHALL return to OCIOSO on the next edge.

Reset
REQ-027 When reset_n=0, the block SHALL immediately enter OCIOSO, regardless of clock.
REQ-028 During reset, tx SHALL be NOP; valor, etapa, rodada and soma SHALL be 0; ocupado and fim SHALL be 0.
REQ-029 Reset asserted mid-run SHALL abort the run without a fim pulse and with no further LOAD issued.

Configuration
REQ-030 With macro CONTROLE_CARGA_ACUMULA_EN defined, at each ESPERA capture the block SHALL update soma<=soma+entrada, saturating at 8'd255.
REQ-031 With CONTROLE_CARGA_ACUMULA_EN undefined, soma SHALL be constant 0 and no adder SHALL be synthesized.

Verification
REQ-032 Reset, then start=1 for one cycle with a memory model returning 2,3,5 -> exactly three single-cycle tx=LOAD pulses; valor 2, 3, 5 in turn; fim pulses 16 cycles after the first CARREGA; soma=10 (macro on) or 0 (macro off).
REQ-033 Memory returns 3 -> etapa reads 3,2,1 on successive EXECUTA cycles, then 0, and the block enters the next CARREGA.
REQ-034 Memory returns 0 in round 1 -> no EXECUTA cycle for that round; round 2 CARREGA follows ESPERA directly.
REQ-035 start pulsed again during EXECUTA -> ignored; after fim, the block stays in OCIOSO with ocupado=0.
REQ-036 reset_n driven low during round 2 EXECUTA -> tx=NOP and all outputs 0 with no clock edge; no fim pulse; the next start begins at rodada=0.
REQ-037 Macro on, RODADAS=31, memory always returns 31 -> soma saturates at 255 and does not wrap.

Source files
------------

// File: rtl/controle_carga.sv
// Load/execute sequencer: per round it requests one memory value, waits for it,
// then burns that many execute cycles. Optional accumulator: CONTROLE_CARGA_ACUMULA_EN.
module controle_carga #(
  parameter logic [4:0]  LOAD    = 5'd1,
  parameter logic [4:0]  NOP     = 5'd0,
  parameter int unsigned RODADAS = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [4:0] entrada,
  output logic [4:0] tx,
  output logic [4:0] valor,
  output logic [4:0] etapa,
  output logic [4:0] rodada,
  output logic       ocupado,
  output logic       fim,
  output logic [7:0] soma
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ESPERA  = 3'd2,
    EXECUTA = 3'd3,
    FIM     = 3'd4
  } estado_t;

  localparam logic [4:0] ULTIMA = 5'(RODADAS - 1);

  estado_t    estado, proximo;
  logic [4:0] tx_next;
  logic       limpa, captura, decrementa, avanca, fim_rodada;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado <= OCIOSO;
      tx     <= NOP;
    end else begin
      estado <= proximo;
      tx     <= tx_next;
    end
  end

  always_comb begin
    proximo    = estado;
    limpa      = 1'b0;
    captura    = 1'b0;
    decrementa = 1'b0;
    avanca     = 1'b0;
    fim_rodada = 1'b0;
    case (estado)
      OCIOSO: begin
        if (start) begin
          proximo = CARREGA;
          limpa   = 1'b1;
        end
      end
      CARREGA: proximo = ESPERA;
      ESPERA: begin
        captura = 1'b1;
        if (entrada != 5'd0) proximo = EXECUTA;
        else                 fim_rodada = 1'b1;
      end
      EXECUTA: begin
        decrementa = 1'b1;
        if (etapa == 5'd1) fim_rodada = 1'b1;
      end
      FIM:     proximo = OCIOSO;
      default: proximo = OCIOSO;
    endcase
    // A zero-length round leaves straight from ESPERA through the same round-end rule
    if (fim_rodada) begin
      if (rodada == ULTIMA) begin
        proximo = FIM;
      end else begin
        proximo = CARREGA;
        avanca  = 1'b1;
      end
    end
    // tx is registered, so it is set up one edge ahead of the CARREGA cycle
    tx_next = (proximo == CARREGA) ? LOAD : NOP;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valor  <= '0;
      etapa  <= '0;
      rodada <= '0;
    end else begin
      if (limpa)       rodada <= '0;
      else if (avanca) rodada <= rodada + 5'd1;
      if (captura) begin
        valor <= entrada;
        etapa <= entrada;
      end else if (decrementa) begin
        etapa <= etapa - 5'd1;
      end
    end
  end

  assign ocupado = (estado != OCIOSO);
  assign fim     = (estado == FIM);

`ifdef CONTROLE_CARGA_ACUMULA_EN
  logic [8:0] soma_ext;
  assign soma_ext = {1'b0, soma} + {4'b0000, entrada};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     soma <= '0;
    else if (limpa)   soma <= '0;
    else if (captura) soma <= soma_ext[8] ? '1 : soma_ext[7:0];
  end
`else
  assign soma = '0;
`endif

endmodule

// File: tb/tb_controle_carga.sv
// Scoreboarded bench for controle_carga: a run-level model predicts LOAD/fim events,
// per-cycle etapa and the busy window; a monitor compares on every falling edge.
module tb_controle_carga;

  localparam logic [4:0] LOAD = 5'd1;
  localparam logic [4:0] NOP  = 5'd0;
  localparam int R = 3;
`ifdef CONTROLE_CARGA_ACUMULA_EN
  localparam bit ACUM = 1'b1;
`else
  localparam bit ACUM = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n, start;
  logic [4:0] entrada, tx, valor, etapa, rodada;
  logic       ocupado, fim;
  logic [7:0] soma;

  logic       start31;
  logic [4:0] entrada31, tx31, valor31, etapa31, rodada31;
  logic       ocupado31, fim31;
  logic [7:0] soma31;

  controle_carga #(.LOAD(LOAD), .NOP(NOP), .RODADAS(R)) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .entrada(entrada),
    .tx(tx), .valor(valor), .etapa(etapa), .rodada(rodada),
    .ocupado(ocupado), .fim(fim), .soma(soma)
  );

  controle_carga #(.LOAD(LOAD), .NOP(NOP), .RODADAS(31)) u_sat (
    .clock(clock), .reset_n(reset_n), .start(start31), .entrada(entrada31),
    .tx(tx31), .valor(valor31), .etapa(etapa31), .rodada(rodada31),
    .ocupado(ocupado31), .fim(fim31), .soma(soma31)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit carga;
    int ciclo;
    int valor;
    int rodada;
    int soma;
  } evento_t;

  int      checks = 0;
  int      errors = 0;
  int      ciclo  = 0;
  int      win_lo = 1;
  int      win_hi = 0;
  int      prev_valor = 0;
  evento_t exp_q[$];
  int      exp_etapa[int];
  int      mem_q[$];
  logic [4:0] vals [R];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ciclo);
    end
  endtask

  function automatic int acum(input int s, input int v);
    if (!ACUM) return 0;
    return (s + v > 255) ? 255 : s + v;
  endfunction

  always @(posedge clock) ciclo <= ciclo + 1;

  // memory block: advances once per LOAD command
  always @(posedge clock) begin
    if (tx == LOAD) begin
      if (mem_q.size() > 0) entrada <= 5'(mem_q.pop_front());
      else                  entrada <= 5'd0;
    end
  end

  bit         tem;
  logic [4:0] exp_tx;
  evento_t    ev;
  always @(negedge clock) begin
    tem    = (exp_q.size() > 0) && (exp_q[0].ciclo == ciclo);
    exp_tx = (tem && exp_q[0].carga) ? LOAD : NOP;
    chk("tx", int'(tx), int'(exp_tx));
    chk("fim", int'(fim), int'(tem && !exp_q[0].carga));
    chk("ocupado", int'(ocupado), int'(ciclo >= win_lo && ciclo <= win_hi));
    chk("etapa", int'(etapa), exp_etapa.exists(ciclo) ? exp_etapa[ciclo] : 0);
    if (tem) begin
      ev = exp_q.pop_front();
      chk(ev.carga ? "valor_load" : "valor_fim", int'(valor), ev.valor);
      chk(ev.carga ? "rodada_load" : "rodada_fim", int'(rodada), ev.rodada);
      chk(ev.carga ? "soma_load" : "soma_fim", int'(soma), ev.soma);
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_tx"}, int'(tx), int'(NOP));
    chk({tag, "_valor"}, int'(valor), 0);
    chk({tag, "_etapa"}, int'(etapa), 0);
    chk({tag, "_rodada"}, int'(rodada), 0);
    chk({tag, "_soma"}, int'(soma), 0);
    chk({tag, "_ocupado"}, int'(ocupado), 0);
    chk({tag, "_fim"}, int'(fim), 0);
  endtask

  // Predicts a whole run from vals[], starts it, optionally pokes start or aborts
  task automatic do_run(input bit poke, input bit abort);
    int t0, c, s, c_abort, pick;
    @(negedge clock);
    t0 = ciclo + 1;
    c  = t0;
    s  = 0;
    c_abort = 0;
    for (int r = 0; r < R; r++) begin
      exp_q.push_back('{carga: 1'b1, ciclo: c, valor: (r == 0) ? prev_valor : int'(vals[r-1]),
                        rodada: r, soma: s});
      mem_q.push_back(int'(vals[r]));
      for (int k = 1; k <= int'(vals[r]); k++) exp_etapa[c + 1 + k] = int'(vals[r]) - k + 1;
      if (r == 1) c_abort = c + 2;
      s = acum(s, int'(vals[r]));
      c = c + 2 + int'(vals[r]);
    end
    exp_q.push_back('{carga: 1'b0, ciclo: c, valor: int'(vals[R-1]), rodada: R - 1, soma: s});
    win_lo = t0;
    win_hi = c;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (abort) begin
      while (ciclo < c_abort) @(negedge clock);
      #2 reset_n = 1'b0;
      #1 check_zero("abort");
      exp_q.delete();
      mem_q.delete();
      exp_etapa.delete();
      win_hi = ciclo;
      prev_valor = 0;
      @(negedge clock);
      @(negedge clock);
      #2 reset_n = 1'b1;
      @(negedge clock);
    end else begin
      if (poke) begin
        pick = t0 + 1 + $urandom_range(0, c - t0 - 1);
        while (ciclo < pick) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
      while (ciclo < c + 3) @(negedge clock);
      prev_valor = int'(vals[R-1]);
    end
  endtask

  initial begin
    int t_sat;
    bit visto;
    reset_n   = 1'b0;
    start     = 1'b0;
    start31   = 1'b0;
    entrada   = 5'd0;
    entrada31 = 5'd31;
    @(negedge clock);
    @(negedge clock);
    #1 check_zero("reset");
    #1 reset_n = 1'b1;

    vals = '{5'd2, 5'd3, 5'd5};
    do_run(1'b1, 1'b0);
    vals = '{5'd4, 5'd0, 5'd3};
    do_run(1'b0, 1'b0);
    vals = '{5'd1, 5'd3, 5'd2};
    do_run(1'b0, 1'b1);
    vals = '{5'd0, 5'd0, 5'd0};
    do_run(1'b1, 1'b0);
    for (int n = 0; n < 20; n++) begin
      for (int r = 0; r < R; r++)
        vals[r] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 9));
      do_run(1'($urandom_range(0, 1)), 1'b0);
    end

    // 31 rounds of value 31: accumulator must clamp, not wrap
    @(negedge clock);
    start31 = 1'b1;
    t_sat   = ciclo + 1;
    @(negedge clock);
    start31 = 1'b0;
    visto   = 1'b0;
    for (int i = 0; i < 1200 && !visto; i++) begin
      if (fim31) visto = 1'b1;
      else @(negedge clock);
    end
    chk("sat_fim_seen", int'(visto), 1);
    if (visto) begin
      chk("sat_fim_cycle", ciclo - t_sat, 2 * 31 + 31 * 31);
      chk("sat_soma", int'(soma31), ACUM ? 255 : 0);
      chk("sat_valor", int'(valor31), 31);
      chk("sat_rodada", int'(rodada31), 30);
      @(negedge clock);
      chk("sat_ocupado_after", int'(ocupado31), 0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
